// File: rtl/prga.sv
// ARC4 pseudo-random generation stage.
// Reads a length-prefixed ciphertext from CT-RAM and writes the length byte
// followed by L plaintext bytes to PT-RAM. Each plaintext byte is the
// keystream pad XOR the ciphertext byte.
// The permuted S array is already in S-RAM and is swapped in place as the
// keystream advances. All memories have one cycle of read latency, so every
// read is split into an address state followed by a data state.
module prga #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LEN,
    S_WR_LEN,
    S_RD_SI,
    S_RD_SJ,
    S_WR_SI,
    S_WR_SJ,
    S_RD_PAD,
    S_WR_PT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i, j, k, len, si, sj;

  // State register; reset returns to IDLE immediately, which drops both write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever order the statements are in.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Cipher indices and the two swap operands, each updated in the state whose read data it captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      len <= '0;
      si  <= '0;
      sj  <= '0;
    end else begin
      case (state)
        S_WR_LEN: begin
          len <= ct_rddata;
          i   <= '0;
          j   <= '0;
          k   <= 8'd1;
        end
        S_RD_SI:  i <= i + 8'd1;
        S_RD_SJ: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        S_WR_SI:  sj <= s_rddata;
        // k stops at len, so a 255-byte message never wraps k back to 0.
        S_WR_PT:  if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  // Next-state and output decode. Memory ports idle at zero outside their own states.
  always_comb begin
    // NOTE: every output and state_nxt gets a default before the case, so
    // states that leave a signal untouched cannot infer a latch.
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = S_RD_LEN;
      end
      S_RD_LEN: state_nxt = S_WR_LEN;
      S_WR_LEN: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        state_nxt = (ct_rddata == 8'd0) ? S_IDLE : S_RD_SI;
      end
      S_RD_SI: begin
        s_addr    = i + 8'd1;
        state_nxt = S_RD_SJ;
      end
      S_RD_SJ: begin
        s_addr    = j + s_rddata;
        state_nxt = S_WR_SI;
      end
      S_WR_SI: begin
        s_addr    = i;
        s_wrdata  = s_rddata;
        s_wren    = 1'b1;
        state_nxt = S_WR_SJ;
      end
      S_WR_SJ: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = S_RD_PAD;
      end
      // The pad read follows the swap writes, so it sees the post-swap S.
      S_RD_PAD: begin
        s_addr    = si + sj;
        ct_addr   = ADDR_W'(k);
        state_nxt = S_WR_PT;
      end
      S_WR_PT: begin
        pt_addr   = ADDR_W'(k);
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        state_nxt = (k == len) ? S_IDLE : S_RD_SI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Bench for prga. It models S-, CT- and PT-RAM with one-cycle read latency.
// A vector table covers the basic messages. Hand-written sequences cover
// en held high, reset in mid-message and the 255-byte maximum.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  prga #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [0:255];
  logic [7:0] pt_mem [0:255];
  logic [7:0] ct_mem [0:255];
  logic [7:0] m_s    [0:255];
  logic [7:0] exp_pt [0:255];

  // Loader port: the bench preloads S and clears PT one entry per cycle while the DUT is idle.
  logic       ld = 1'b0;
  logic [7:0] ld_addr = '0, ld_s = '0, ld_pt = '0;
  int         s_wr_cnt = 0, pt_wr_cnt = 0;

  always @(posedge clk) begin
    if (s_wren)  s_mem[s_addr] <= s_wrdata;
    else if (ld) s_mem[ld_addr] <= ld_s;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    else if (ld) pt_mem[ld_addr] <= ld_pt;
    if (s_wren)  s_wr_cnt  <= s_wr_cnt + 1;
    if (pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ident_model();
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
  endtask

  // Key scheduling for key "Key" (4B 65 79).
  task automatic ksa_model();
    logic [7:0] key [0:2];
    logic [7:0] jj, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    ident_model();
    jj = '0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + m_s[x] + key[x % 3];
      t = m_s[x]; m_s[x] = m_s[jj]; m_s[jj] = t;
    end
  endtask

  // Reference keystream: processes nbytes of ct_mem starting from i=j=0 and updates m_s.
  task automatic model_run(input int nbytes);
    logic [7:0] ii, jj, t, idx;
    ii = '0; jj = '0;
    exp_pt[0] = ct_mem[0];
    for (int n = 1; n <= nbytes; n++) begin
      ii = ii + 8'd1;
      jj = jj + m_s[ii];
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      idx = m_s[ii] + m_s[jj];
      exp_pt[n] = m_s[idx] ^ ct_mem[n];
    end
  endtask

  task automatic load_mems();
    ld = 1'b1;
    for (int x = 0; x < 256; x++) begin
      ld_addr = 8'(x); ld_s = m_s[x]; ld_pt = 8'hEE;
      step();
    end
    ld = 1'b0;
    step();
  endtask

  task automatic run_msg(output int busy);
    en = 1'b1;
    step();
    en = 1'b0;
    busy = 0;
    while (!rdy && busy < 2000) begin
      busy++;
      step();
    end
  endtask

  task automatic check_s(input string name);
    int bad;
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    check(name, bad, 0);
  endtask

  typedef struct {
    bit              ksa;
    logic [7:0]      len;
    logic [0:9][7:0] ct;
    logic [0:9][7:0] pt;
    int              busy;
    int              swr;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int busy, sw0, pw0, low;

    vecs[0] = '{ksa: 1'b0, len: 8'd1, ct: 80'h01_00_00_00_00_00_00_00_00_00,
                pt: 80'h01_02_00_00_00_00_00_00_00_00, busy: 8, swr: 2};
    vecs[1] = '{ksa: 1'b0, len: 8'd0, ct: 80'h00_00_00_00_00_00_00_00_00_00,
                pt: 80'h00_00_00_00_00_00_00_00_00_00, busy: 2, swr: 0};
    vecs[2] = '{ksa: 1'b0, len: 8'd2, ct: 80'h02_00_00_00_00_00_00_00_00_00,
                pt: 80'h02_02_05_00_00_00_00_00_00_00, busy: 14, swr: 4};
    vecs[3] = '{ksa: 1'b1, len: 8'd9, ct: 80'h09_BB_F3_16_E8_D9_40_AF_0A_D3,
                pt: 80'h09_50_6C_61_69_6E_74_65_78_74, busy: 56, swr: 18};

    // Reset state.
    step(); step();
    check("rst_rdy", rdy, 1);
    check("rst_s_wren", s_wren, 0);
    check("rst_pt_wren", pt_wren, 0);
    check("rst_addrs", {s_addr, ct_addr, pt_addr}, 0);
    check("rst_wrdata", {s_wrdata, pt_wrdata}, 0);
    rst_n = 1'b1;
    step();

    // Table-driven messages.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].ksa) ksa_model(); else ident_model();
      for (int x = 0; x < 256; x++) ct_mem[x] = (x < 10) ? vecs[v].ct[x] : 8'h00;
      load_mems();
      sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
      run_msg(busy);
      model_run(int'(vecs[v].len));
      check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
      check($sformatf("v%0d_s_writes", v), s_wr_cnt - sw0, vecs[v].swr);
      check($sformatf("v%0d_pt_writes", v), pt_wr_cnt - pw0, int'(vecs[v].len) + 1);
      for (int n = 0; n <= int'(vecs[v].len); n++)
        check($sformatf("v%0d_pt%0d", v, n), pt_mem[n], vecs[v].pt[n]);
      check_s($sformatf("v%0d_s_final", v));
    end

    // en held high: one run, one IDLE cycle, then a second run on the updated S.
    ksa_model();
    for (int x = 0; x < 256; x++) ct_mem[x] = (x < 10) ? vecs[3].ct[x] : 8'h00;
    load_mems();
    en = 1'b1;
    step();
    busy = 0;
    while (!rdy && busy < 2000) begin busy++; step(); end
    model_run(9);
    check("hold_run1_busy", busy, 56);
    for (int n = 0; n <= 9; n++)
      check($sformatf("hold_run1_pt%0d", n), pt_mem[n], vecs[3].pt[n]);
    step();
    check("hold_restart", rdy, 0);
    en = 1'b0;
    busy = 0;
    while (!rdy && busy < 2000) begin busy++; step(); end
    model_run(9);
    check("hold_run2_busy", busy, 56);
    for (int n = 0; n <= 9; n++)
      check($sformatf("hold_run2_pt%0d", n), pt_mem[n], exp_pt[n]);
    check_s("hold_run2_s");
    low = 0;
    for (int c = 0; c < 3; c++) begin step(); if (!rdy) low++; end
    check("hold_no_third_run", low, 0);

    // Reset asserted in WR_SI of byte 3.
    ident_model();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    ct_mem[0] = 8'h04; ct_mem[1] = 8'h11; ct_mem[2] = 8'h22; ct_mem[3] = 8'h33; ct_mem[4] = 8'h44;
    load_mems();
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (16) step();
    check("rst_mid_in_wr_si", s_wren, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_s_wren", s_wren, 0);
    check("rst_mid_rdy", rdy, 1);
    step();
    rst_n = 1'b1;
    step();
    model_run(2);
    check_s("rst_mid_partial_s");
    run_msg(busy);
    model_run(4);
    check("rst_mid_restart_busy", busy, 26);
    for (int n = 0; n <= 4; n++)
      check($sformatf("rst_mid_pt%0d", n), pt_mem[n], exp_pt[n]);
    check_s("rst_mid_final_s");

    // Maximum length message, L=255.
    ident_model();
    ct_mem[0] = 8'hFF;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    load_mems();
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
    run_msg(busy);
    model_run(255);
    check("l255_busy", busy, 2 + 6 * 255);
    check("l255_pt_writes", pt_wr_cnt - pw0, 256);
    check("l255_s_writes", s_wr_cnt - sw0, 510);
    for (int n = 0; n < 256; n++)
      check($sformatf("l255_pt%0d", n), pt_mem[n], exp_pt[n]);
    check_s("l255_s_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
